// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//
// Phase scheduler for a two-road intersection. Sequences the lamps through the
// green -> yellow -> (all-red) phases of both roads. It also handles pedestrian
// walk service, emergency-vehicle preemption and emergency green hold. It owns
// the phase counter.
//
// Optional feature macro: SCHED_ALLRED_EN
//   defined   : Y1 -> AR1 -> G2 and Y2 -> AR2 -> G1 (all-red clearance)
//   undefined : Y1 -> G2 and Y2 -> G1 directly
//
// Ports
//   clk_1s                  in   1 Hz clock
//   rst_n                   in   synchronous active-low reset
//   ped_req_1 / ped_req_2   in   pedestrian buttons (pulse or level)
//   emg_req_1 / emg_req_2   in   emergency vehicle approaching, level
//   green_x/yellow_x/red_x  out  road lamps, one lit per road
//   walk_1 / walk_2         out  pedestrian walk lamps
//   ped_pending_1 / _2      out  latched, not yet served pedestrian request
//   emg_hold                out  a green is held past its end by its own
//                                road's emergency request
//
// state | meaning
// ------+---------------------------------------------
// G1    | road 1 green, road 2 red
// Y1    | road 1 yellow, road 2 red
// AR1   | both red after road 1 (SCHED_ALLRED_EN only)
// G2    | road 2 green, road 1 red
// Y2    | road 2 yellow, road 1 red
// AR2   | both red after road 2 (SCHED_ALLRED_EN only)
// -----------------------------------------------------------------------------
module intersection_scheduler #(
  parameter int GREEN1_TIME = 40,
  parameter int GREEN2_TIME = 20,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2,
  parameter int MIN_GREEN   = 10,
  parameter int WALK_TIME   = 10,
  parameter int CNT_W       = 6
) (
  input  logic clk_1s,
  input  logic rst_n,
  input  logic ped_req_1,
  input  logic ped_req_2,
  input  logic emg_req_1,
  input  logic emg_req_2,
  output logic green_1,
  output logic yellow_1,
  output logic red_1,
  output logic green_2,
  output logic yellow_2,
  output logic red_2,
  output logic walk_1,
  output logic walk_2,
  output logic ped_pending_1,
  output logic ped_pending_2,
  output logic emg_hold
);

  typedef enum logic [2:0] {
    ST_G1  = 3'd0,
    ST_Y1  = 3'd1,
    ST_G2  = 3'd2,
    ST_Y2  = 3'd3
`ifdef SCHED_ALLRED_EN
    ,
    ST_AR1 = 3'd4,
    ST_AR2 = 3'd5
`endif
  } state_e;

  localparam logic [CNT_W-1:0] G1_END   = CNT_W'(GREEN1_TIME - 1);
  localparam logic [CNT_W-1:0] G2_END   = CNT_W'(GREEN2_TIME - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] MING_END = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(WALK_TIME);
`ifdef SCHED_ALLRED_EN
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_TIME - 1);
`else
  localparam int unused_allred_time = ALLRED_TIME;
`endif

  state_e           state_q, state_d, nxt_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend1_q, pend1_d;
  logic             pend2_q, pend2_d;
  logic             served_q, served_d;
  logic             advance;

  always_comb begin
    state_d   = state_q;
    nxt_state = state_q;
    cnt_d     = cnt_q + 1'b1;
    served_d  = served_q;
    pend1_d   = pend1_q | ped_req_1;
    pend2_d   = pend2_q | ped_req_2;
    advance   = 1'b0;

    case (state_q)
      ST_G1: begin
        nxt_state = ST_Y1;
        if (cnt_q == G1_END) begin
          // Own-road emergency freezes the green at its last second.
          if (emg_req_1) cnt_d = cnt_q;
          else           advance = 1'b1;
        end else if (emg_req_2 && !emg_req_1 && (cnt_q >= MING_END)) begin
          advance = 1'b1;
        end
      end
      ST_Y1: begin
`ifdef SCHED_ALLRED_EN
        nxt_state = ST_AR1;
`else
        nxt_state = ST_G2;
`endif
        advance = (cnt_q == Y_END);
      end
`ifdef SCHED_ALLRED_EN
      ST_AR1: begin
        nxt_state = ST_G2;
        advance   = (cnt_q == AR_END);
      end
`endif
      ST_G2: begin
        nxt_state = ST_Y2;
        if (cnt_q == G2_END) begin
          if (emg_req_2) cnt_d = cnt_q;
          else           advance = 1'b1;
        end else if (emg_req_1 && !emg_req_2 && (cnt_q >= MING_END)) begin
          advance = 1'b1;
        end
      end
      ST_Y2: begin
`ifdef SCHED_ALLRED_EN
        nxt_state = ST_AR2;
`else
        nxt_state = ST_G1;
`endif
        advance = (cnt_q == Y_END);
      end
`ifdef SCHED_ALLRED_EN
      ST_AR2: begin
        nxt_state = ST_G1;
        advance   = (cnt_q == AR_END);
      end
`endif
      default: begin
        nxt_state = ST_G1;
        advance   = 1'b1;
      end
    endcase

    if (advance) begin
      state_d = nxt_state;
      cnt_d   = '0;
      // Entering a green consumes that road's pending request; a press on
      // the same edge re-arms it for the following green.
      if (nxt_state == ST_G1) begin
        served_d = pend1_q;
        pend1_d  = ped_req_1;
      end
      if (nxt_state == ST_G2) begin
        served_d = pend2_q;
        pend2_d  = ped_req_2;
      end
    end
  end

  always_ff @(posedge clk_1s) begin
    if (!rst_n) begin
      state_q  <= ST_G1;
      cnt_q    <= '0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      served_q <= served_d;
    end
  end

  // Outputs are forced to the G1 reset pattern while rst_n is low so the
  // lamps are safe even before the first reset edge.
  always_comb begin
    green_1       = 1'b0;
    yellow_1      = 1'b0;
    red_1         = 1'b0;
    green_2       = 1'b0;
    yellow_2      = 1'b0;
    red_2         = 1'b0;
    walk_1        = 1'b0;
    walk_2        = 1'b0;
    ped_pending_1 = 1'b0;
    ped_pending_2 = 1'b0;
    emg_hold      = 1'b0;
    if (!rst_n) begin
      green_1 = 1'b1;
      red_2   = 1'b1;
    end else begin
      ped_pending_1 = pend1_q;
      ped_pending_2 = pend2_q;
      case (state_q)
        ST_Y1: begin
          yellow_1 = 1'b1;
          red_2    = 1'b1;
        end
        ST_G2: begin
          red_1    = 1'b1;
          green_2  = 1'b1;
          walk_2   = served_q && (cnt_q < WALK_LIM);
          emg_hold = emg_req_2 && (cnt_q == G2_END);
        end
        ST_Y2: begin
          red_1    = 1'b1;
          yellow_2 = 1'b1;
        end
`ifdef SCHED_ALLRED_EN
        ST_AR1, ST_AR2: begin
          red_1 = 1'b1;
          red_2 = 1'b1;
        end
`endif
        ST_G1: begin
          green_1  = 1'b1;
          red_2    = 1'b1;
          walk_1   = served_q && (cnt_q < WALK_LIM);
          emg_hold = emg_req_1 && (cnt_q == G1_END);
        end
        default: begin
          green_1 = 1'b1;
          red_2   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for intersection_scheduler. A phase-table model tracks the expected
// behaviour and is compared against the DUT on every falling clock edge. Each
// directed scenario also pins a few literal expectations. A randomized run
// follows the directed scenarios.
// -----------------------------------------------------------------------------
module tb_intersection_scheduler;

  localparam int MIN_GREEN = 10;
  localparam int WALK_TIME = 10;
`ifdef SCHED_ALLRED_EN
  localparam int AR = 2;
`else
  localparam int AR = 0;
`endif

  // lamp vector order {green_1, yellow_1, red_1, green_2, yellow_2, red_2}
  localparam logic [5:0] L_G1 = 6'b100001;
  localparam logic [5:0] L_Y1 = 6'b010001;
  localparam logic [5:0] L_AR = 6'b001001;
  localparam logic [5:0] L_G2 = 6'b001100;
  localparam logic [5:0] L_Y2 = 6'b001010;

  logic clk_1s = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req_1 = 1'b0, ped_req_2 = 1'b0;
  logic emg_req_1 = 1'b0, emg_req_2 = 1'b0;
  logic green_1, yellow_1, red_1, green_2, yellow_2, red_2;
  logic walk_1, walk_2, ped_pending_1, ped_pending_2, emg_hold;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 0;

  always #5 clk_1s = ~clk_1s;

  intersection_scheduler dut (
    .clk_1s(clk_1s), .rst_n(rst_n),
    .ped_req_1(ped_req_1), .ped_req_2(ped_req_2),
    .emg_req_1(emg_req_1), .emg_req_2(emg_req_2),
    .green_1(green_1), .yellow_1(yellow_1), .red_1(red_1),
    .green_2(green_2), .yellow_2(yellow_2), .red_2(red_2),
    .walk_1(walk_1), .walk_2(walk_2),
    .ped_pending_1(ped_pending_1), .ped_pending_2(ped_pending_2),
    .emg_hold(emg_hold)
  );

  wire [5:0] lamps = {green_1, yellow_1, red_1, green_2, yellow_2, red_2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: phase list with durations -------------
  // phase 0 G1, 1 Y1, 2 AR1, 3 G2, 4 Y2, 5 AR2; zero-duration phases are skipped
  function automatic int dur_of(input int p);
    case (p)
      0: return 40;
      1: return 5;
      3: return 20;
      4: return 5;
      default: return AR;
    endcase
  endfunction

  function automatic logic [5:0] lamp_of(input int p);
    case (p)
      0: return L_G1;
      1: return L_Y1;
      3: return L_G2;
      4: return L_Y2;
      default: return L_AR;
    endcase
  endfunction

  int m_p = 0, m_t = 0;
  bit m_pend1 = 0, m_pend2 = 0, m_served = 0;

  always @(posedge clk_1s) begin
    bit own, oth, leave, hold, op1, op2;
    int np;
    if (!rst_n) begin
      m_p = 0; m_t = 0; m_pend1 = 0; m_pend2 = 0; m_served = 0;
    end else begin
      leave = 0; hold = 0;
      op1 = m_pend1; op2 = m_pend2;
      if (m_p == 0 || m_p == 3) begin
        own = (m_p == 0) ? emg_req_1 : emg_req_2;
        oth = (m_p == 0) ? emg_req_2 : emg_req_1;
        if (m_t == dur_of(m_p) - 1) begin
          hold = own;
          leave = !own;
        end else if (oth && !own && m_t >= MIN_GREEN - 1) begin
          leave = 1;
        end
      end else begin
        leave = (m_t == dur_of(m_p) - 1);
      end
      m_pend1 = m_pend1 | ped_req_1;
      m_pend2 = m_pend2 | ped_req_2;
      if (leave) begin
        np = (m_p + 1) % 6;
        while (dur_of(np) == 0) np = (np + 1) % 6;
        m_p = np;
        m_t = 0;
        if (np == 0) begin m_served = op1; m_pend1 = ped_req_1; end
        if (np == 3) begin m_served = op2; m_pend2 = ped_req_2; end
      end else if (!hold) begin
        m_t++;
      end
    end
  end

  function automatic logic [10:0] model_out();
    logic [5:0] l;
    logic w1, w2, h;
    if (!rst_n) return {L_G1, 5'b0};
    l  = lamp_of(m_p);
    w1 = (m_p == 0) && m_served && (m_t < WALK_TIME);
    w2 = (m_p == 3) && m_served && (m_t < WALK_TIME);
    h  = ((m_p == 0) && emg_req_1 && (m_t == dur_of(0) - 1)) ||
         ((m_p == 3) && emg_req_2 && (m_t == dur_of(3) - 1));
    return {l, w1, w2, m_pend1, m_pend2, h};
  endfunction

  always @(negedge clk_1s) begin
    if (chk_en)
      check("outputs", {21'b0, lamps, walk_1, walk_2, ped_pending_1, ped_pending_2, emg_hold},
            {21'b0, model_out()});
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    ped_req_1 = 0; ped_req_2 = 0; emg_req_1 = 0; emg_req_2 = 0;
    rst_n = 0;
    @(posedge clk_1s); #1;
    rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk_1s); #1;
  endtask

  initial begin
    #1;
    do_reset();
    chk_en = 1;

    // 1: free-running cycle, no requests
    for (int c = 0; c < 72 + 2 * AR; c++) begin
      @(negedge clk_1s);
      if (c == 0)            check("s1_g1_start", {26'b0, lamps}, {26'b0, L_G1});
      if (c == 39)           check("s1_g1_end",   {26'b0, lamps}, {26'b0, L_G1});
      if (c == 40)           check("s1_y1_start", {26'b0, lamps}, {26'b0, L_Y1});
      if (c == 44)           check("s1_y1_end",   {26'b0, lamps}, {26'b0, L_Y1});
      if (c == 45)           check("s1_after_y1", {26'b0, lamps}, {26'b0, (AR > 0) ? L_AR : L_G2});
      if (c == 45 + AR)      check("s1_g2_start", {26'b0, lamps}, {26'b0, L_G2});
      if (c == 64 + AR)      check("s1_g2_end",   {26'b0, lamps}, {26'b0, L_G2});
      if (c == 65 + AR)      check("s1_y2_start", {26'b0, lamps}, {26'b0, L_Y2});
      if (c == 69 + AR)      check("s1_y2_end",   {26'b0, lamps}, {26'b0, L_Y2});
      if (c == 70 + 2 * AR)  check("s1_g1_again", {26'b0, lamps}, {26'b0, L_G1});
      next_cycle();
    end

    // 2: pedestrian request for road 2
    do_reset();
    for (int c = 0; c < 60 + AR; c++) begin
      ped_req_2 = (c == 5);
      @(negedge clk_1s);
      if (c == 5)       check("s2_pend_before", {31'b0, ped_pending_2}, 32'd0);
      if (c == 6)       check("s2_pend_set",    {31'b0, ped_pending_2}, 32'd1);
      if (c == 44 + AR) check("s2_pend_held",   {31'b0, ped_pending_2}, 32'd1);
      if (c == 45 + AR) check("s2_pend_clear",  {31'b0, ped_pending_2}, 32'd0);
      if (c == 45 + AR) check("s2_walk_start",  {31'b0, walk_2}, 32'd1);
      if (c == 54 + AR) check("s2_walk_last",   {31'b0, walk_2}, 32'd1);
      if (c == 55 + AR) check("s2_walk_off",    {31'b0, walk_2}, 32'd0);
      if (c == 50)      check("s2_walk1_off",   {31'b0, walk_1}, 32'd0);
      next_cycle();
    end

    // 3: emergency on road 2 preempts road 1 green at minimum green
    do_reset();
    for (int c = 0; c < 30; c++) begin
      emg_req_2 = (c >= 3 && c < 25);
      @(negedge clk_1s);
      if (c == 9)       check("s3_g1_last",  {26'b0, lamps}, {26'b0, L_G1});
      if (c == 10)      check("s3_y1",       {26'b0, lamps}, {26'b0, L_Y1});
      if (c == 15 + AR) check("s3_g2",       {26'b0, lamps}, {26'b0, L_G2});
      next_cycle();
    end

    // 4: emergency on road 1 holds its green
    do_reset();
    for (int c = 0; c < 64; c++) begin
      emg_req_1 = (c >= 30 && c <= 59);
      @(negedge clk_1s);
      if (c == 38) check("s4_hold_before", {31'b0, emg_hold}, 32'd0);
      if (c == 39) check("s4_hold_start",  {31'b0, emg_hold}, 32'd1);
      if (c == 59) check("s4_hold_last",   {31'b0, emg_hold}, 32'd1);
      if (c == 60) check("s4_g1_release",  {26'b0, lamps}, {26'b0, L_G1});
      if (c == 60) check("s4_hold_off",    {31'b0, emg_hold}, 32'd0);
      if (c == 61) check("s4_y1",          {26'b0, lamps}, {26'b0, L_Y1});
      next_cycle();
    end

    // 5: reset during road 2 green with a pending road-1 request
    do_reset();
    for (int c = 0; c < 93; c++) begin
      ped_req_1 = (c == 48);
      rst_n = (c != 50);
      @(negedge clk_1s);
      if (c == 49) check("s5_pend_before", {31'b0, ped_pending_1}, 32'd1);
      if (c == 50) check("s5_rst_lamps",   {26'b0, lamps}, {26'b0, L_G1});
      if (c == 51) check("s5_after_lamps", {26'b0, lamps}, {26'b0, L_G1});
      if (c == 51) check("s5_after_pend",  {31'b0, ped_pending_1}, 32'd0);
      if (c == 90) check("s5_g1_end",      {26'b0, lamps}, {26'b0, L_G1});
      if (c == 91) check("s5_y1",          {26'b0, lamps}, {26'b0, L_Y1});
      next_cycle();
    end
    rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      ped_req_1 = ($urandom_range(0, 19) == 0);
      ped_req_2 = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) emg_req_1 = ~emg_req_1;
      if ($urandom_range(0, 39) == 0) emg_req_2 = ~emg_req_2;
      rst_n = ($urandom_range(0, 799) != 0);
      next_cycle();
    end

    @(negedge clk_1s);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
